// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM march BIST: controller states, failing-element codes
// and the read/write phase bit used by the two-cycle march elements.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0W1,
        ST_R1W0,
        ST_RB,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        ELEM_NONE = 2'd0,
        ELEM_R0W1 = 2'd1,
        ELEM_R1W0 = 2'd2,
        ELEM_RB   = 2'd3
    } elem_e;

    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_e;

endpackage

// File: rtl/bist_addr_gen.sv
// N-bit up/down address counter with synchronous load; 'last' flags the
// terminal address of the current direction so elements never wrap.
module bist_addr_gen #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         en_i,
    input  logic         down_i,
    output logic [N-1:0] addr_o,
    output logic         last_o
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (en_i) begin
            addr_d = down_i ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == {N{1'b1}});

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator for the dual-port RAM: W0, R0W1, R1W0 (descending), then a
// port-B read-back, latching the first mismatch and reporting pass/fail.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 16,
    parameter int               N       = 4,
    parameter logic [WIDTH-1:0] PATTERN = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_elem,
    output logic [N-1:0]     fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic             we_a,
    output logic             we_b,
    output logic [N-1:0]     addr_a,
    output logic [N-1:0]     addr_b,
    output logic [WIDTH-1:0] din_a,
    output logic [WIDTH-1:0] din_b,
    input  logic [WIDTH-1:0] dout_a,
    input  logic [WIDTH-1:0] dout_b
);

    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [N-1:0] TOP_ADDR = N'(DEPTH - 1);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic             tail_q, tail_d;
    logic             fail_q, fail_d;
    logic [1:0]       elem_q, elem_d;
    logic [N-1:0]     faddr_q, faddr_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;

    logic             cnt_load, cnt_en, cnt_down, cnt_last;
    logic [N-1:0]     cnt_load_val, cnt;
    logic             we_raw, mis;
    logic [WIDTH-1:0] exp_a;
    logic [N-1:0]     rb_addr;

    bist_addr_gen #(.N(N)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .down_i     (cnt_down),
        .addr_o     (cnt),
        .last_o     (cnt_last)
    );

    assign cnt_down = (state_q == ST_R1W0);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        tail_d       = tail_q;
        fail_d       = fail_q;
        elem_d       = elem_q;
        faddr_d      = faddr_q;
        fdata_d      = fdata_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        we_raw       = 1'b0;
        mis          = 1'b0;
        exp_a        = PATTERN;
        rb_addr      = '0;
        busy         = 1'b0;
        done         = 1'b0;
        addr_a       = '0;
        din_a        = '0;
        addr_b       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_W0;
                    cnt_load = 1'b1;
                end
            end

            ST_W0: begin
                busy   = 1'b1;
                we_raw = 1'b1;
                addr_a = cnt;
                din_a  = PATTERN;
                if (cnt_last) begin
                    state_d  = ST_R0W1;
                    phase_d  = PH_READ;
                    cnt_load = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_R0W1, ST_R1W0: begin
                busy   = 1'b1;
                addr_a = cnt;
                exp_a  = (state_q == ST_R0W1) ? PATTERN : ~PATTERN;
                if (phase_q == PH_READ) begin
                    phase_d = PH_WRITE;
                end else begin
                    // dout_a here is the data from the read issued in the previous cycle
                    we_raw = 1'b1;
                    din_a  = ~exp_a;
                    if (dout_a != exp_a) begin
                        mis     = 1'b1;
                        fail_d  = 1'b1;
                        elem_d  = (state_q == ST_R0W1) ? ELEM_R0W1 : ELEM_R1W0;
                        faddr_d = cnt;
                        fdata_d = dout_a;
                        state_d = ST_DONE;
                    end else if (cnt_last) begin
                        phase_d  = PH_READ;
                        cnt_load = 1'b1;
                        if (state_q == ST_R0W1) begin
                            state_d      = ST_R1W0;
                            cnt_load_val = TOP_ADDR;
                        end else begin
                            state_d = ST_RB;
                            tail_d  = 1'b0;
                        end
                    end else begin
                        phase_d = PH_READ;
                        cnt_en  = 1'b1;
                    end
                end
            end

            ST_RB: begin
                busy = 1'b1;
                if (!tail_q) begin
                    addr_b = cnt;
                end
                // Compare trails the presented address by one cycle; the tail cycle checks the top word.
                rb_addr = tail_q ? cnt : (cnt - ONE);
                if ((tail_q || (cnt != '0)) && (dout_b != PATTERN)) begin
                    mis     = 1'b1;
                    fail_d  = 1'b1;
                    elem_d  = ELEM_RB;
                    faddr_d = rb_addr;
                    fdata_d = dout_b;
                    state_d = ST_DONE;
                end else if (tail_q) begin
                    state_d = ST_DONE;
                end else if (cnt_last) begin
                    tail_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d  = ST_W0;
                    cnt_load = 1'b1;
                    fail_d   = 1'b0;
                    elem_d   = ELEM_NONE;
                    faddr_d  = '0;
                    fdata_d  = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        we_a = we_raw && !mis;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_READ;
            tail_q  <= 1'b0;
            fail_q  <= 1'b0;
            elem_q  <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tail_q  <= tail_d;
            fail_q  <= fail_d;
            elem_q  <= elem_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    assign fail      = fail_q;
    assign fail_elem = elem_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;
    assign we_b      = 1'b0;
    assign din_b     = '0;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural dual-port RAM with fault injection, plus an
// array-level march model predicting verdict, busy length, write count and contents.
module tb_ram_bist_ctrl;

    localparam int          WIDTH = 8;
    localparam int          DEPTH = 16;
    localparam int          N     = 4;
    localparam logic [7:0]  P     = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, fail, we_a, we_b;
    logic [1:0]       fail_elem;
    logic [N-1:0]     fail_addr, addr_a, addr_b;
    logic [WIDTH-1:0] fail_data, din_a, din_b, dout_a, dout_b;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N), .PATTERN(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_elem (fail_elem),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .din_a     (din_a),
        .din_b     (din_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b)
    );

    // Fault configuration shared by the RAM model and the reference model
    bit         stuck_en = 1'b0;
    int         stuck_addr = 0;
    int         stuck_bit = 0;
    logic       stuck_val = 1'b0;
    bit         pb_en = 1'b0;
    int         pb_addr = 0;
    logic [7:0] pb_val = 8'h00;

    function automatic logic [7:0] stored(input int a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    logic [7:0] ram [DEPTH];
    int         nwrites = 0;

    always @(posedge clk) begin
        if (we_a) begin
            ram[addr_a] <= stored(int'(addr_a), din_a);
            nwrites     <= nwrites + 1;
        end
        dout_a <= ram[addr_a];
        dout_b <= (pb_en && int'(addr_b) == pb_addr) ? pb_val : ram[addr_b];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, fail, fail_elem, fail_addr, fail_data,
                    we_a, we_b, addr_a, addr_b, din_a, din_b});
    endfunction

    // Reference model: the march algorithm over a plain array
    bit         exp_fail;
    int         exp_elem, exp_addr, exp_busy, exp_writes;
    logic [7:0] exp_data;
    logic [7:0] exp_mem [DEPTH];

    task automatic model_run();
        logic [7:0] r;
        logic [7:0] want;
        int cyc;
        int i;
        exp_fail = 1'b0; exp_elem = 0; exp_addr = 0; exp_data = 8'h00;
        exp_writes = 0; cyc = 0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_mem[k] = stored(k, P);
            exp_writes++;
            cyc++;
        end
        for (int e = 1; e <= 2; e++) begin
            want = (e == 1) ? P : ~P;
            for (int k = 0; k < DEPTH; k++) begin
                i = (e == 1) ? k : DEPTH - 1 - k;
                cyc += 2;
                r = exp_mem[i];
                if (r !== want) begin
                    exp_fail = 1'b1; exp_elem = e; exp_addr = i; exp_data = r;
                    exp_busy = cyc;
                    return;
                end
                exp_mem[i] = stored(i, ~want);
                exp_writes++;
            end
        end
        cyc++;
        for (int k = 0; k < DEPTH; k++) begin
            cyc++;
            r = (pb_en && k == pb_addr) ? pb_val : exp_mem[k];
            if (r !== P) begin
                exp_fail = 1'b1; exp_elem = 3; exp_addr = k; exp_data = r;
                exp_busy = cyc;
                return;
            end
        end
        exp_busy = cyc;
    endtask

    task automatic run_bist(input string tag, input int busy_start_at, input int reset_at);
        int n;
        int w0;
        int nbad;
        model_run();
        w0 = nwrites;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy1"}, 64'(busy), 64'(1));
        chk({tag, ".clr"}, 64'({done, fail, fail_elem, fail_addr, fail_data}), 64'(0));
        chk({tag, ".w0"}, 64'({we_a, addr_a, din_a}), 64'({1'b1, 4'd0, P}));
        n = 0;
        while (busy && n < 200) begin
            n++;
            start = (n == busy_start_at);
            if (n == reset_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                chk({tag, ".rst_outs"}, outs(), 64'(0));
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".len"}, 64'(n), 64'(exp_busy));
        chk({tag, ".done"}, 64'(done), 64'(1));
        chk({tag, ".fail"}, 64'(fail), 64'(exp_fail));
        chk({tag, ".elem"}, 64'(fail_elem), 64'(exp_elem));
        chk({tag, ".addr"}, 64'(fail_addr), 64'(exp_addr));
        chk({tag, ".data"}, 64'(fail_data), 64'(exp_data));
        chk({tag, ".writes"}, 64'(nwrites - w0), 64'(exp_writes));
        nbad = 0;
        for (int k = 0; k < DEPTH; k++) if (ram[k] !== exp_mem[k]) nbad++;
        chk({tag, ".mem"}, 64'(nbad), 64'(0));
        @(negedge clk);
        chk({tag, ".hold"}, 64'({busy, done, we_a, addr_b}), 64'({1'b0, 1'b1, 1'b0, 4'd0}));
    endtask

    task automatic no_faults();
        stuck_en = 1'b0;
        pb_en    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.outs", outs(), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.outs", outs(), 64'(0));

        no_faults();
        run_bist("clean", 0, 0);

        stuck_en = 1'b1; stuck_addr = 9; stuck_bit = 0; stuck_val = 1'b1;
        run_bist("stuck", 0, 0);
        chk("stuck.fields", 64'({fail, fail_elem, fail_addr, fail_data}),
            64'({1'b1, 2'd2, 4'd9, 8'h5B}));

        no_faults();
        run_bist("restart", 0, 0);

        pb_en = 1'b1; pb_addr = 3; pb_val = 8'h00;
        run_bist("portb", 0, 0);
        chk("portb.fields", 64'({fail, fail_elem, fail_addr, fail_data}),
            64'({1'b1, 2'd3, 4'd3, 8'h00}));

        no_faults();
        run_bist("busystart", 40, 0);
        run_bist("midreset", 0, 50);
        run_bist("postreset", 0, 0);

        for (int it = 0; it < 24; it++) begin
            int ft;
            ft         = int'($urandom_range(0, 2));
            stuck_en   = (ft == 1);
            pb_en      = (ft == 2);
            stuck_addr = int'($urandom_range(0, DEPTH - 1));
            stuck_bit  = int'($urandom_range(0, WIDTH - 1));
            stuck_val  = 1'($urandom_range(0, 1));
            pb_addr    = int'($urandom_range(0, DEPTH - 1));
            pb_val     = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_bist($sformatf("rand%0d", it), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
